// File: rtl/rf.sv
// 32 x 32-bit register file: two combinational read ports and one synchronous write port.
// Each register resets to its own index, and register 0 always reads as zero.
module rf #(
    parameter int WIDTH  = 32,
    parameter int AWIDTH = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AWIDTH-1:0] Address1,
    input  logic [AWIDTH-1:0] Address2,
    output logic [WIDTH-1:0]  Source1,
    output logic [WIDTH-1:0]  Source2,
    input  logic              WriteEn,
    input  logic [AWIDTH-1:0] WriteAddress,
    input  logic [WIDTH-1:0]  WriteData
);

    localparam int DEPTH = 2 ** AWIDTH;

    logic [WIDTH-1:0] regs [DEPTH];

    // NOTE: every entry has a reset value, so this array is built from flops and
    // cannot map onto a RAM macro. The known index values after reset need this.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= WIDTH'(i);
            end
        end else if (WriteEn && (WriteAddress != '0)) begin
            // NOTE: non-blocking update, so a read in the same cycle sees the old value.
            regs[WriteAddress] <= WriteData;
        end
    end

    // Address 0 is decoded explicitly, so it reads as zero independent of storage.
    assign Source1 = (Address1 == '0) ? '0 : regs[Address1];
    assign Source2 = (Address2 == '0) ? '0 : regs[Address2];

endmodule

// File: tb/tb_rf.sv
// Directed self-checking bench for rf: reset values, port independence, writes,
// the register-0 guard, write-enable gating and asynchronous reset.
module tb_rf;

    localparam int WIDTH  = 32;
    localparam int AWIDTH = 5;

    logic              clk;
    logic              rst_n;
    logic [AWIDTH-1:0] Address1;
    logic [AWIDTH-1:0] Address2;
    logic [WIDTH-1:0]  Source1;
    logic [WIDTH-1:0]  Source2;
    logic              WriteEn;
    logic [AWIDTH-1:0] WriteAddress;
    logic [WIDTH-1:0]  WriteData;

    int n_checks = 0;
    int n_fail   = 0;

    rf #(.WIDTH(WIDTH), .AWIDTH(AWIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .Address1     (Address1),
        .Address2     (Address2),
        .Source1      (Source1),
        .Source2      (Source2),
        .WriteEn      (WriteEn),
        .WriteAddress (WriteAddress),
        .WriteData    (WriteData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] actual,
                         input logic [WIDTH-1:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Drives a write at the falling edge, checks the old value just before the
    // rising edge and the new value just after it.
    task automatic do_write(input logic [AWIDTH-1:0] addr, input logic [WIDTH-1:0] data,
                            input logic [WIDTH-1:0] old_val, input logic [WIDTH-1:0] new_val,
                            input string tag);
        @(negedge clk);
        WriteEn      = 1'b1;
        WriteAddress = addr;
        WriteData    = data;
        Address1     = addr;
        #1 check({tag, "_before"}, Source1, old_val);
        @(posedge clk);
        #1 check({tag, "_after"}, Source1, new_val);
        @(negedge clk);
        WriteEn = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        Address1     = '0;
        Address2     = '0;
        WriteEn      = 1'b0;
        WriteAddress = '0;
        WriteData    = '0;

        #12;
        check("reset_r0", Source1, 32'h0000_0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Pair sweep of the reset values.
        for (int i = 0; i < 32; i += 2) begin
            Address1 = AWIDTH'(i);
            Address2 = AWIDTH'(i + 1);
            #1;
            check($sformatf("sweep_s1_%0d", i), Source1, WIDTH'(i));
            check($sformatf("sweep_s2_%0d", i + 1), Source2, WIDTH'(i + 1));
            #9;
        end

        // Both ports on the same register.
        Address1 = 5'd17;
        Address2 = 5'd17;
        #1;
        check("same_s1", Source1, 32'h0000_0011);
        check("same_s2", Source2, 32'h0000_0011);

        // Write register 5; its neighbour must be untouched.
        do_write(5'd5, 32'hDEAD_BEEF, 32'h0000_0005, 32'hDEAD_BEEF, "wr5");
        Address2 = 5'd6;
        #1 check("wr5_neighbour6", Source2, 32'h0000_0006);

        // Register 0 ignores writes.
        do_write(5'd0, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, "wr0");

        // WriteEn low across several edges leaves register 9 alone.
        @(negedge clk);
        WriteEn      = 1'b0;
        WriteAddress = 5'd9;
        WriteData    = 32'h1234_5678;
        Address1     = 5'd9;
        repeat (3) @(posedge clk);
        #1 check("we_low_r9", Source1, 32'h0000_0009);
        Address1 = 5'd5;
        #1 check("r5_kept", Source1, 32'hDEAD_BEEF);

        // Asynchronous reset between edges restores index values at once.
        Address2 = 5'd31;
        do_write(5'd31, 32'hAAAA_5555, 32'h0000_001F, 32'hAAAA_5555, "wr31");
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_r31", Source2, 32'h0000_001F);
        Address1 = 5'd5;
        #1 check("async_rst_r5", Source1, 32'h0000_0005);

        // A write presented while reset is held is discarded.
        WriteEn      = 1'b1;
        WriteAddress = 5'd31;
        WriteData    = 32'h0BAD_F00D;
        @(posedge clk);
        #1 check("rst_write_discard", Source2, 32'h0000_001F);

        // The first edge after reset release accepts the write.
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("post_rst_write", Source2, 32'h0BAD_F00D);
        @(negedge clk);
        WriteEn = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
